// File: rtl/alu_pkg.sv
// alu_pkg: operation encoding shared by the z23 ALU and its controllers.
package alu_pkg;
   typedef enum logic [3:0] {
      ADD8, ADC8, SUB8, SBC8, AND8, OR8, XOR8, CP8,
      ADD16, ADC16, SUB16, SBC16, INC8, DEC8, INC16, DEC16
   } alu_op_t;
endpackage

// File: rtl/cu_pkg.sv
// cu_pkg: control-unit flag layout and ALU issue/consume state encoding.
package cu_pkg;
   localparam int FLAG_C = 0;
   localparam int FLAG_V = 2;
   localparam int FLAG_Z = 6;
   localparam int FLAG_S = 7;
   localparam logic [7:0] FLAG_MASK_ALL = 8'hFF;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} exec_state_t;
endpackage

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: issues one command to the combinational ALU, captures its result
// and merges its flags into F under a per-command mask.
module alu_exec_ctrl
   import alu_pkg::*;
   import cu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FLAG_W = 8
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              req_valid,
   output logic              req_ready,
   input  alu_op_t           req_op,
   input  logic [DATA_W-1:0] req_x,
   input  logic [DATA_W-1:0] req_y,
   input  logic              req_cin,
   input  logic              req_use_fc,
   input  logic [FLAG_W-1:0] req_flag_mask,
   output alu_op_t           alu_op,
   output logic [DATA_W-1:0] alu_x,
   output logic [DATA_W-1:0] alu_y,
   output logic              alu_cin,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [FLAG_W-1:0] alu_flag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic [FLAG_W-1:0] f_reg,
   input  logic              f_wr_en,
   input  logic [FLAG_W-1:0] f_wr_data
);
   exec_state_t       state;
   logic [FLAG_W-1:0] mask;
   logic [FLAG_W-1:0] f_base;
   assign req_ready = (state == IDLE) | ((state == RESP) & rsp_ready);
   assign f_base = f_wr_en ? f_wr_data : f_reg;
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         alu_op     <= ADD8;
         alu_x      <= '0;
         alu_y      <= '0;
         alu_cin    <= 1'b0;
         mask       <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         f_reg      <= '0;
      end else if (state == EXEC) begin
         rsp_result <= alu_result;
         f_reg      <= (f_base & ~mask) | (alu_flag & mask);
         rsp_valid  <= 1'b1;
         state      <= RESP;
      end else begin
         f_reg <= f_base;
         // carry-in sees F as it was before this edge, including back-to-back
         if (req_valid && req_ready) begin
            alu_op    <= req_op;
            alu_x     <= req_x;
            alu_y     <= req_y;
            alu_cin   <= req_use_fc ? f_reg[FLAG_C] : req_cin;
            mask      <= req_flag_mask;
            rsp_valid <= 1'b0;
            state     <= EXEC;
         end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed vectors against alu_exec_ctrl with a behavioural
// 8080-style ALU (S Z 0 AC 0 P/V 1 C) driving the result/flag inputs.
module tb_alu_exec_ctrl;
   import alu_pkg::*;

   typedef struct {
      alu_op_t     op;
      logic [15:0] x;
      logic [15:0] y;
      logic        cin;
      logic        fc;
      logic [7:0]  mask;
      logic        set_f;
      logic [7:0]  f_init;
      logic        wr_exec;
      logic [7:0]  wr_data;
      logic        exp_cin;
      logic [15:0] exp_res;
      logic [7:0]  exp_f;
   } vec_t;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   alu_op_t     req_op = ADD8;
   logic [15:0] req_x = '0;
   logic [15:0] req_y = '0;
   logic        req_cin = 1'b0;
   logic        req_use_fc = 1'b0;
   logic [7:0]  req_flag_mask = '0;
   alu_op_t     alu_op;
   logic [15:0] alu_x, alu_y;
   logic        alu_cin;
   logic [15:0] alu_result;
   logic [7:0]  alu_flag;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_result;
   logic [7:0]  f_reg;
   logic        f_wr_en = 1'b0;
   logic [7:0]  f_wr_data = '0;
   int          total = 0;
   int          bad = 0;
   vec_t        vecs[8];

   always #5 clk = ~clk;

   alu_exec_ctrl dut (
      .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
      .req_use_fc(req_use_fc), .req_flag_mask(req_flag_mask), .alu_op(alu_op),
      .alu_x(alu_x), .alu_y(alu_y), .alu_cin(alu_cin), .alu_result(alu_result),
      .alu_flag(alu_flag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .f_reg(f_reg), .f_wr_en(f_wr_en), .f_wr_data(f_wr_data)
   );

   function automatic logic [23:0] alu_model(alu_op_t op, logic [15:0] x, logic [15:0] y, logic cin);
      logic [8:0]  s8;
      logic [4:0]  h;
      logic [16:0] s16;
      logic [15:0] res;
      logic        c, ac, v, ci, sgn;
      s8 = '0; h = '0; s16 = '0; res = x; c = 1'b0; ac = 1'b0; v = 1'b0;
      ci = (op == ADC8 || op == SBC8) ? cin : 1'b0;
      case (op)
         ADD8, ADC8: begin
            s8 = {1'b0, x[7:0]} + {1'b0, y[7:0]} + 9'(ci);
            h = {1'b0, x[3:0]} + {1'b0, y[3:0]} + 5'(ci);
            res = {8'h00, s8[7:0]}; c = s8[8]; ac = h[4];
            v = (x[7] == y[7]) && (s8[7] != x[7]);
         end
         SUB8, SBC8: begin
            s8 = {1'b0, x[7:0]} - {1'b0, y[7:0]} - 9'(ci);
            h = {1'b0, x[3:0]} - {1'b0, y[3:0]} - 5'(ci);
            res = {8'h00, s8[7:0]}; c = s8[8]; ac = h[4];
            v = (x[7] != y[7]) && (s8[7] != x[7]);
         end
         AND8: begin res = {8'h00, x[7:0] & y[7:0]}; v = ~^res[7:0]; end
         OR8:  begin res = {8'h00, x[7:0] | y[7:0]}; v = ~^res[7:0]; end
         XOR8: begin res = {8'h00, x[7:0] ^ y[7:0]}; v = ~^res[7:0]; end
         ADD16: begin
            s16 = {1'b0, x} + {1'b0, y};
            res = s16[15:0]; c = s16[16];
            v = (x[15] == y[15]) && (s16[15] != x[15]);
         end
         default: res = x;
      endcase
      sgn = (op == ADD16) ? res[15] : res[7];
      return {sgn, res == 16'h0, 1'b0, ac, 1'b0, v, 1'b1, c, res};
   endfunction

   always_comb {alu_flag, alu_result} = alu_model(alu_op, alu_x, alu_y, alu_cin);

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preset_f(logic [7:0] v);
      f_wr_en = 1'b1; f_wr_data = v;
      @(negedge clk);
      f_wr_en = 1'b0;
      chk("f_direct_write", 32'(f_reg), 32'(v));
   endtask

   task automatic drive_req(alu_op_t op, logic [15:0] x, logic [15:0] y, logic cin, logic fc, logic [7:0] m);
      req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
      req_cin = cin; req_use_fc = fc; req_flag_mask = m;
   endtask

   task automatic run_vec(int i);
      vec_t v;
      v = vecs[i];
      if (v.set_f) preset_f(v.f_init);
      drive_req(v.op, v.x, v.y, v.cin, v.fc, v.mask);
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(v.op));
      chk($sformatf("v%0d_alu_cin", i), 32'(alu_cin), 32'(v.exp_cin));
      chk($sformatf("v%0d_exec_valid", i), 32'(rsp_valid), 32'd0);
      f_wr_en = v.wr_exec; f_wr_data = v.wr_data;
      @(negedge clk);
      f_wr_en = 1'b0;
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d_result", i), 32'(rsp_result), 32'(v.exp_res));
      chk($sformatf("v%0d_f_reg", i), 32'(f_reg), 32'(v.exp_f));
      @(negedge clk);
      chk($sformatf("v%0d_idle_valid", i), 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      vecs[0] = '{ADD8, 16'h0045, 16'h00E5, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h002A, 8'h03};
      vecs[1] = '{ADC8, 16'h0025, 16'h0057, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 16'h007D, 8'h02};
      vecs[2] = '{SUB8, 16'h0057, 16'h0025, 1'b0, 1'b0, 8'h01, 1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 16'h0032, 8'h02};
      vecs[3] = '{AND8, 16'h3457, 16'h3276, 1'b0, 1'b0, 8'h04, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 16'h0056, 8'hA5};
      vecs[4] = '{XOR8, 16'h0001, 16'h0000, 1'b0, 1'b0, 8'h04, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 16'h0001, 8'hA1};
      vecs[5] = '{OR8,  16'h000F, 16'h00F0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 16'h00FF, 8'h5A};
      vecs[6] = '{SBC8, 16'h0010, 16'h0001, 1'b1, 1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 16'h000F, 8'h00};
      vecs[7] = '{ADC8, 16'h0010, 16'h0020, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 16'h0030, 8'h01};

      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_f_reg", 32'(f_reg), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'(ADD8));
      chk("rst_alu_x", 32'(alu_x), 32'd0);
      chk("rst_alu_cin", 32'(alu_cin), 32'd0);
      chk("rst_result", 32'(rsp_result), 32'd0);
      nrst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(i);

      // stalled response, then back-to-back accept whose carry sees the new F
      preset_f(8'h81);
      rsp_ready = 1'b0;
      drive_req(ADD16, 16'h5678, 16'h1245, 1'b0, 1'b0, 8'h01);
      @(negedge clk);
      drive_req(ADC8, 16'h0010, 16'h0001, 1'b1, 1'b1, 8'h00);
      chk("bb_exec_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd1);
         chk($sformatf("stall%0d_result", k), 32'(rsp_result), 32'h68BD);
         chk($sformatf("stall%0d_ready", k), 32'(req_ready), 32'd0);
         chk($sformatf("stall%0d_alu_x", k), 32'(alu_x), 32'h5678);
         @(negedge clk);
      end
      chk("stall_f_reg", 32'(f_reg), 32'h80);
      rsp_ready = 1'b1;
      #1 chk("bb_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bb_alu_x", 32'(alu_x), 32'h0010);
      chk("bb_alu_cin", 32'(alu_cin), 32'd0);
      chk("bb_exec_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("bb_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bb_result", 32'(rsp_result), 32'h0011);
      chk("bb_f_reg", 32'(f_reg), 32'h80);
      @(negedge clk);
      chk("bb_idle_valid", 32'(rsp_valid), 32'd0);

      // asynchronous reset in the middle of EXEC
      preset_f(8'hFF);
      drive_req(SUB8, 16'h0057, 16'h0025, 1'b0, 1'b0, 8'hFF);
      @(negedge clk);
      req_valid = 1'b0;
      chk("ar_alu_op_before", 32'(alu_op), 32'(SUB8));
      nrst = 1'b0;
      #1;
      chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("ar_f_reg", 32'(f_reg), 32'd0);
      chk("ar_alu_op", 32'(alu_op), 32'(ADD8));
      chk("ar_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      nrst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("ar%0d_no_rsp", k), 32'(rsp_valid), 32'd0);
         chk($sformatf("ar%0d_f_reg", k), 32'(f_reg), 32'd0);
         chk($sformatf("ar%0d_ready", k), 32'(req_ready), 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Control-side issuer and consumer for the combinational z23 ALU.
- Accepts one ALU command per valid/ready handshake and drives registered operands, carry-in and alu_op into the ALU.
- Captures the result and merges the ALU flags into the architectural F register under a per-command mask.
- Returns the result through a valid/ready response channel. It sits between the control unit's decode/operand fetch and register writeback.

Parameters:
DATA_W, 16, operand/result width (ALU X/Y/result width; fixed by ALU)
FLAG_W, 8, width of cu_pkg::f_register

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when high with req_valid
req_op  in  alu_pkg::alu_op  operation
req_x  in  16  operand X
req_y  in  16  operand Y
req_cin  in  1  explicit carry-in
req_use_fc  in  1  1: carry-in taken from F[FLAG_C] instead of req_cin
req_flag_mask  in  8  F bits updated by this command (1 = take ALU flag)
alu_op  out  alu_pkg::alu_op  to ALU
alu_x  out  16  to ALU X
alu_y  out  16  to ALU Y
alu_cin  out  1  to ALU Cin
alu_result  in  16  from ALU result
alu_flag  in  8  from ALU flag
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_result  out  16  captured ALU result
f_reg  out  8  architectural F register
f_wr_en  in  1  direct F write strobe (POP AF etc.)
f_wr_data  in  8  direct F write value

Behaviour:
- Reset (async, nrst low):
  - State is IDLE.
  - alu_op=ADD8; alu_x, alu_y, alu_cin, rsp_result, f_reg and rsp_valid are all 0.
  - Reset mid-command aborts it; no response is produced and F is not updated.
- FSM states: IDLE, EXEC, RESP.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready). It is combinational from state and rsp_ready.
- Accept edge (req_valid & req_ready):
  - Latch req_op, req_x and req_y into alu_op/alu_x/alu_y registers.
  - Latch alu_cin = req_use_fc ? f_reg[FLAG_C] : req_cin, using the F value before this edge.
  - Latch req_flag_mask.
  - Next state is EXEC.
- EXEC (exactly 1 cycle; ALU is combinational on registered inputs). On the edge leaving EXEC:
  - rsp_result <= alu_result.
  - f_reg <= (f_base & ~mask) | (alu_flag & mask), where f_base = f_wr_en ? f_wr_data : f_reg.
  - Next state is RESP.
- RESP:
  - rsp_valid=1; rsp_result and f_reg are held stable until rsp_ready.
  - On rsp_ready without a new request: go to IDLE and drop rsp_valid.
  - On rsp_ready with req_valid: accept back-to-back and go to EXEC. The new command's use_fc sees the already-updated F.
- Latency: accept at edge N, rsp_valid high after edge N+1. Throughput is 1 command per 2 cycles.
- alu_* outputs hold their last values outside EXEC; they change only on accept edges.
- Direct F write:
  - In IDLE/RESP, f_wr_en loads f_wr_data on the next edge.
  - In EXEC, masked bits take the ALU value and unmasked bits take f_wr_data.
- A mask of 0 leaves F unchanged except for a simultaneous f_wr_en. A mask of 0xFF replaces F entirely.
- req_* inputs are ignored while req_ready=0.

Decomposition:
- cu_pkg gains flag index constants FLAG_C=0, FLAG_V=2, FLAG_Z=6, FLAG_S=7, the FLAG_MASK_ALL=8'hFF constant, and the exec_state_t enum (IDLE/EXEC/RESP).
- alu_op stays in alu_pkg.
- No sub-module inside. The ALU is instantiated beside this block at the control-unit level and in the bench.

Test Plan:
- ADD8 X=0x0045 Y=0x00E5 cin=0 mask=0xFF with rsp_ready=1: rsp_valid one cycle after accept, rsp_result=0x002A, f_reg=0x03.
- Then ADC use_fc=1 X=0x0025 Y=0x0057 mask=0xFF: alu_cin=1 (from F.C), rsp_result=0x007D, f_reg=0x02.
- F=0x03, then SUB8 X=0x0057 Y=0x0025 mask=0x01: rsp_result=0x0032, f_reg=0x02 (only C cleared).
- Hold rsp_ready=0 for 3 cycles after ADD16 X=0x5678 Y=0x1245: rsp_valid stays 1, rsp_result stays 0x68BD, req_ready=0. Raise rsp_ready with req_valid=1 (AND) to get a back-to-back accept on the same edge.
- f_wr_en=1 f_wr_data=0xA5 during EXEC of AND X=0x3457 Y=0x3276 mask=0x04: rsp_result=0x0056, f_reg=0xA5 (bit2 from ALU = 1).
- Assert nrst low during EXEC: immediately rsp_valid=0, f_reg=0x00, alu_op=ADD8, state IDLE. After release, req_ready=1 and no stale response appears.
